sram_sp_arb: RTL and testbench

Two-requester arbiter and sequencer for one single-port SRAM bank (`SRAM_SP`). It shares the bank between a write channel (DMA fill) and a read channel (PE operand fetch). It issues at most one SRAM access per cycle, prevents read starvation under continuous writes, and returns read data with a fixed one-cycle latency. It sits between the buffer-fill/fetch controllers and each `SRAM_SP` instance.

---
 rtl/sram_sp_arb.sv | 143 ++++++++++++++
 tb/tb_sram_sp_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_arb.sv
// Write/read arbiter and command sequencer for one single-port SRAM bank.
// Build option SRAM_ARB_RR_EN: strict round-robin instead of write-priority with starvation guard.

package sram_sp_pkg;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} SP_rwmode;
endpackage

module sram_sp_arb
    import sram_sp_pkg::*;
#(
    parameter int WORDWD     = 256,
    parameter int DWD        = 16,
    parameter int AWD        = $clog2(WORDWD),
    parameter int SIZE       = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [AWD-1:0]                i_wr_addr,
    input  logic [DWD-1:0]                i_wr_data [SIZE],
    input  logic                          i_rd_valid,
    output logic                          o_rd_ready,
    input  logic [AWD-1:0]                i_rd_addr,
    output logic                          o_rd_rvalid,
    output logic [DWD-1:0]                o_rd_rdata [SIZE],
    output SP_rwmode                      o_sram_rw,
    output logic                          o_sram_ce,
    output logic [AWD-1:0]                o_sram_addr,
    output logic [DWD-1:0]                o_sram_wdata [SIZE],
    input  logic [DWD-1:0]                i_sram_rdata [SIZE],
    output logic [$clog2(STARVE_LIM+1)-1:0] o_starve_cnt
);

    localparam int SCW = $clog2(STARVE_LIM + 1);

    logic wr_grant_s;
    logic rd_grant_s;
    logic rd_win_s;
    logic rvalid_r;

`ifdef SRAM_ARB_RR_EN
    logic last_rd_r;

    // Under contention, serve whichever side was not granted last
    always_comb begin
        rd_win_s = ~last_rd_r;
    end

    // Last-grant pointer; reset to read-last so the first contended grant goes to the writer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_rd_r <= 1'b1;
        end else if (rd_grant_s) begin
            last_rd_r <= 1'b1;
        end else if (wr_grant_s) begin
            last_rd_r <= 1'b0;
        end else begin
            last_rd_r <= last_rd_r;
        end
    end

    assign o_starve_cnt = {SCW{1'b0}};
`else
    logic [SCW-1:0] starve_cnt_r;

    // Reads only beat a contending write once they have waited the full limit
    always_comb begin
        rd_win_s = (starve_cnt_r == SCW'(STARVE_LIM));
    end

    // Starvation counter: counts denied read cycles, saturates, clears on a read grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt_r <= {SCW{1'b0}};
        end else if (rd_grant_s) begin
            starve_cnt_r <= {SCW{1'b0}};
        end else if (i_rd_valid && (starve_cnt_r != SCW'(STARVE_LIM))) begin
            starve_cnt_r <= starve_cnt_r + SCW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign o_starve_cnt = starve_cnt_r;
`endif

    // Grant selection: a lone requester always wins, contention resolved by rd_win_s
    always_comb begin
        wr_grant_s = 1'b0;
        rd_grant_s = 1'b0;
        if (i_wr_valid && i_rd_valid) begin
            rd_grant_s = rd_win_s;
            wr_grant_s = ~rd_win_s;
        end else if (i_wr_valid) begin
            wr_grant_s = 1'b1;
        end else if (i_rd_valid) begin
            rd_grant_s = 1'b1;
        end else begin
            wr_grant_s = 1'b0;
            rd_grant_s = 1'b0;
        end
    end

    assign o_wr_ready = wr_grant_s;
    assign o_rd_ready = rd_grant_s;

    // SRAM command for the granted access, idle command otherwise
    always_comb begin
        o_sram_ce   = 1'b0;
        o_sram_rw   = READ;
        o_sram_addr = {AWD{1'b0}};
        if (rd_grant_s) begin
            o_sram_ce   = 1'b1;
            o_sram_rw   = READ;
            o_sram_addr = i_rd_addr;
        end else if (wr_grant_s) begin
            o_sram_ce   = 1'b1;
            o_sram_rw   = WRITE;
            o_sram_addr = i_wr_addr;
        end else begin
            o_sram_ce   = 1'b0;
            o_sram_rw   = READ;
            o_sram_addr = {AWD{1'b0}};
        end
    end

    assign o_sram_wdata = i_wr_data;
    assign o_rd_rdata   = i_sram_rdata;

    // Read response flag tracks the SRAM's one-cycle output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rd_grant_s;
        end
    end

    assign o_rd_rvalid = rvalid_r;

endmodule

// File: tb/tb_sram_sp_arb.sv
// Scoreboard bench for sram_sp_arb with a behavioural single-port SRAM attached.
// Follows SRAM_ARB_RR_EN for the arbitration reference model.

module tb_sram_sp_arb;
    import sram_sp_pkg::*;

    localparam int SLIM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_addr = 8'd0;
    logic [15:0] wr_data [16];
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [7:0]  rd_addr = 8'd0;
    logic        rd_rvalid;
    logic [15:0] rd_rdata [16];
    SP_rwmode    sram_rw;
    logic        sram_ce;
    logic [7:0]  sram_addr;
    logic [15:0] sram_wdata [16];
    logic [15:0] sram_rdata [16];
    logic [2:0]  starve_cnt;

    logic [15:0]  sram_mem [256][16];
    logic [255:0] mem_m [256];
    logic [255:0] exp_q [$];
    int           exp_cnt = 0;
    bit           exp_last_rd = 1'b1;
    bit           exp_rvalid = 1'b0;
    int           n_vec = 0;
    int           n_err = 0;

    sram_sp_arb #(.WORDWD(256), .DWD(16), .AWD(8), .SIZE(16), .STARVE_LIM(SLIM)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_addr(rd_addr),
        .o_rd_rvalid(rd_rvalid), .o_rd_rdata(rd_rdata),
        .o_sram_rw(sram_rw), .o_sram_ce(sram_ce), .o_sram_addr(sram_addr),
        .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata), .o_starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_rw == WRITE) begin
                for (int k = 0; k < 16; k++) sram_mem[sram_addr][k] <= sram_wdata[k];
            end else begin
                for (int k = 0; k < 16; k++) sram_rdata[k] <= sram_mem[sram_addr][k];
            end
        end
    end

    function automatic logic [255:0] pack(input logic [15:0] a [16]);
        logic [255:0] v;
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = a[k];
        return v;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_wdata(input logic [255:0] v);
        for (int k = 0; k < 16; k++) wr_data[k] = v[k*16 +: 16];
    endtask

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge against the reference model, then advance it
    task automatic step(output bit ew, output bit er, output bit rd_obs);
        bit rdwin;
        @(negedge clk);
`ifdef SRAM_ARB_RR_EN
        rdwin = !exp_last_rd;
`else
        rdwin = (exp_cnt == SLIM);
`endif
        if (wr_valid && rd_valid) begin
            er = rdwin;
            ew = !rdwin;
        end else begin
            ew = wr_valid;
            er = rd_valid;
        end
        rd_obs = rd_ready;
        check_val("wr_ready", 256'(wr_ready), 256'(ew));
        check_val("rd_ready", 256'(rd_ready), 256'(er));
        check_val("sram_ce", 256'(sram_ce), 256'(ew | er));
        check_val("sram_rw", 256'(sram_rw), ew ? 256'(WRITE) : 256'(READ));
        check_val("sram_addr", 256'(sram_addr),
                  er ? 256'(rd_addr) : (ew ? 256'(wr_addr) : 256'(0)));
        if (ew) check_val("sram_wdata", pack(sram_wdata), pack(wr_data));
        check_val("starve_cnt", 256'(starve_cnt), 256'(exp_cnt));
        check_val("rd_rvalid", 256'(rd_rvalid), 256'(exp_rvalid));
        if (rd_rvalid) begin
            if (exp_q.size() == 0) check_val("rdata_unexpected", 256'(exp_q.size()), 256'(1));
            else check_val("rd_rdata", pack(rd_rdata), exp_q.pop_front());
        end
        exp_rvalid = er;
        if (er) exp_q.push_back(mem_m[rd_addr]);
        if (ew) mem_m[wr_addr] = pack(wr_data);
`ifdef SRAM_ARB_RR_EN
        if (er) exp_last_rd = 1'b1;
        else if (ew) exp_last_rd = 1'b0;
`else
        if (er) exp_cnt = 0;
        else if (rd_valid && exp_cnt < SLIM) exp_cnt++;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ew, er, ro;
        bit pw, pr;
        int wn;
        int ncont;
        logic [255:0] v;

        set_wdata(256'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (5) step(ew, er, ro);

        // Pre-load 0..7, then write 0x10 with lane index and read it straight back
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_addr = 8'(i); set_wdata(rnd256());
            step(ew, er, ro);
        end
        for (int k = 0; k < 16; k++) v[k*16 +: 16] = 16'(k);
        wr_addr = 8'h10; set_wdata(v);
        step(ew, er, ro);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'h10;
        step(ew, er, ro);
        rd_valid = 1'b0;
        step(ew, er, ro);

        // Continuous writes against a held read
`ifdef SRAM_ARB_RR_EN
        ncont = 6;
`else
        ncont = SLIM + 1;
`endif
        wn = 0;
        wr_valid = 1'b1; wr_addr = 8'h20; set_wdata(rnd256());
        rd_valid = 1'b1; rd_addr = 8'h10;
        for (int i = 0; i < ncont; i++) begin
            step(ew, er, ro);
`ifdef SRAM_ARB_RR_EN
            check_val("rr_alternate", 256'(ro), 256'(i % 2));
`else
            check_val("starve_grant", 256'(ro), 256'(i == SLIM));
`endif
            if (ew) begin
                wn++; wr_addr = 8'(8'h20 + wn); set_wdata(rnd256());
            end
        end
        rd_valid = 1'b0;
        step(ew, er, ro);
        wr_valid = 1'b0;
        step(ew, er, ro);

        // Back-to-back reads of the pre-loaded words
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1; rd_addr = 8'(i);
            step(ew, er, ro);
        end
        rd_valid = 1'b0;
        step(ew, er, ro);

        // Asynchronous reset the cycle after a read grant
        rd_valid = 1'b1; rd_addr = 8'd3;
        step(ew, er, ro);
        rd_valid = 1'b0;
        check_val("rst_pre_rvalid", 256'(rd_rvalid), 256'(1));
        rst_n = 1'b0;
        #1;
        check_val("rst_drop_rvalid", 256'(rd_rvalid), 256'(0));
        exp_q.delete();
        exp_rvalid = 1'b0; exp_cnt = 0; exp_last_rd = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(ew, er, ro);

        // Random traffic, holding requests that were not granted
        pw = 1'b0; pr = 1'b0; ew = 1'b0; er = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!(pw && !ew)) begin
                wr_valid = $urandom_range(0, 1) == 1;
                wr_addr = 8'($urandom_range(0, 15));
                set_wdata(rnd256());
            end
            if (!(pr && !er)) begin
                rd_valid = $urandom_range(0, 1) == 1;
                rd_addr = 8'($urandom_range(0, 7));
            end
            pw = wr_valid; pr = rd_valid;
            step(ew, er, ro);
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        repeat (2) step(ew, er, ro);
        check_val("queue_drained", 256'(exp_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
